loader_write_bridge: RTL
========================

# loader_write_bridge

Buffers byte writes from `game_loader` and replays them into the SDRAM controller's CPU port, one write per NES clock-enable period. It sits between `game_loader` (upstream) and the `sdram` port-A mux (downstream). It replaces the single-entry `loader_write_triggered` handoff with a small FIFO, so that back-to-back loader bytes are never lost. It also reports overflow, busy and progress status to the OSD/ESP32 side.

## Interface
- `ADDR_W`, 22, width of the SDRAM byte address.
- `DATA_W`, 8, width of a data byte.
- `FIFO_DEPTH`, 8, number of FIFO entries; must be a power of two, ≥2.
- `SLOT_PHASE`, 2'd3, value of `nes_ce` on which a write slot is taken.

Ports:
- `clk` in 1: system clock, the same domain as `nes_ce`.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_write` in 1: one-cycle write strobe from `game_loader` `mem_write`.
- `in_addr` in ADDR_W: write address.
- `in_data` in DATA_W: write data.
- `flush` in 1: synchronous clear of the FIFO and of the output write.
- `nes_ce` in 2: free-running NES phase counter.
- `mem_we` out 1: write enable to the SDRAM port A.
- `mem_addr` out ADDR_W: address for the current write.
- `mem_data` out DATA_W: data for the current write.
- `busy` out 1: FIFO non-empty OR `mem_we` high.
- `overflow` out 1: sticky flag; a byte was dropped.
- `write_count` out ADDR_W: number of completed writes, wraps modulo 2^ADDR_W.

## Operation
- FIFO: `FIFO_DEPTH` entries of {addr, data}.
  - Pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - Empty: the pointers are equal.
  - Full: the MSBs differ and the low bits are equal.
- Push: occurs when `in_write` is high and the FIFO is not full.
  - Push while full with no pop in the same cycle: the byte is dropped and `overflow` is set to 1. It stays set until reset or `flush`.
  - Push while full with a pop in the same cycle: the push is accepted.
- Slot edge: a `clk` edge at which `nes_ce == SLOT_PHASE`.
- Output FSM has two states, IDLE (`mem_we=0`) and WRITE (`mem_we=1`). Transitions happen only at slot edges.
  - FIFO non-empty: pop the head into `mem_addr`/`mem_data`, then go to (or stay in) WRITE.
  - FIFO empty: go to IDLE.
  - Leaving WRITE completes one write, so `write_count` increments by 1 at that edge.
- While in WRITE, `mem_addr`, `mem_data` and `mem_we` are held stable for a full `nes_ce` period (4 clks). Consecutive non-empty slots produce back-to-back writes with no gap.
- `mem_addr`/`mem_data` keep their last values in IDLE.
- `flush` has priority over push, pop and the FSM.
  - Next edge after `flush`: pointers equal, `mem_we=0`, state IDLE, `overflow=0`.
  - `write_count` is unchanged by `flush`.
- Simultaneous push and pop on a non-full FIFO: both happen, and the occupancy is unchanged.

## Timing
- Reset values: `mem_we=0`, `mem_addr=0`, `mem_data=0`, `busy=0`, `overflow=0`, `write_count=0`, state IDLE, FIFO empty.
- Reset asserted mid-write: `mem_we` drops immediately (asynchronous), and queued data is discarded.
- No bypass path:
  - A byte pushed at edge t can first be popped at the first slot edge ≥ t+1.
  - Push latency to `mem_we`: minimum 1 clk, maximum 4 clks, when the FIFO is empty.
- Sustained throughput is 1 byte per 4 clks. Loader bursts faster than this are absorbed up to `FIFO_DEPTH` bytes.
- All outputs are registered; there is no combinational path from input to output except `busy`, which is derived from registers only.

## Structure
- Shared package holds the `nes_ce` phase constants (SLOT_PHASE=3, clkref phase) and the `{addr,data}` loader-write record typedef.
- One sub-module: `sync_fifo`, parameterised by width and depth, with `push`/`pop`/`full`/`empty`/`flush`. The bridge contains the FSM, the overflow logic and the counter.

## Test plan
- Single write: after reset, `in_write` with addr 0x000010, data 0xA5, at `nes_ce=0` → `mem_we=1` from the next slot edge (3 clks later) for exactly 4 clks with 0x000010/0xA5; then `write_count=1` and `busy=0`.
- Burst: 8 writes on consecutive clks (addr 0..7, data 0x10..0x17) → 8 back-to-back 4-clk writes in order, no gap, `overflow=0`, final `write_count=8`.
- Overflow: 12 consecutive-clk writes with DEPTH=8 → exactly the bytes that fit are written in order, later bytes are dropped, and `overflow` is 1 and sticky.
- Simultaneous push and pop while full → push accepted, occupancy remains full, no overflow.
- Flush mid-write: 4 entries queued and `mem_we=1`, assert `flush` for 1 clk → next edge `mem_we=0`, `busy=0`, `overflow=0`, `write_count` unchanged.
- Async reset in WRITE: deassert `reset_n` between clk edges → `mem_we` drops at once, all outputs are at reset values, and a subsequent write works normally.

Source files
------------

// File: rtl/loader_write_bridge_pkg.sv
// Shared definitions for the loader write bridge.
//   - NES clock-enable phase constants (write slot phase, clkref phase)
//   - loader write record {addr, data}
//   - output FSM state encoding
package loader_write_bridge_pkg;

   localparam int unsigned LDR_ADDR_W = 22;
   localparam int unsigned LDR_DATA_W = 8;

   // nes_ce value on which the SDRAM CPU-port write slot is taken
   localparam logic [1:0] NES_SLOT_PHASE   = 2'd3;
   // nes_ce value on which the NES core sees clkref
   localparam logic [1:0] NES_CLKREF_PHASE = 2'd0;

   typedef struct packed {
      logic [LDR_ADDR_W-1:0] addr;
      logic [LDR_DATA_W-1:0] data;
   } ldr_wr_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } wr_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers and a synchronous flush.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   flush             : clears both pointers (priority over push/pop)
//   push, wdata       : write request and payload
//   pop               : read request (head advances)
//   rdata             : current head entry (valid when !empty)
//   full, empty       : occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 30,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   // Occupancy flags from the pointer pair
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
   assign rdata = mem_q[rd_ptr_q[IDX_W-1:0]];

   // Pointer update; a pop frees the head slot so a full-FIFO push can land
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_pop   = pop & ~empty & ~flush;
      do_push  = push & ~flush & (~full | do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/loader_write_bridge.sv
// Buffers game_loader byte writes and replays them into the SDRAM CPU port,
// one write per nes_ce period, taken on the slot phase.
// Ports:
//   clk, reset_n                : clock, async active-low reset
//   in_write, in_addr, in_data  : loader write strobe and payload
//   flush                       : synchronous clear of FIFO, write and overflow
//   nes_ce                      : free-running NES phase counter
//   mem_we, mem_addr, mem_data  : SDRAM port-A write (held for a full period)
//   busy                        : FIFO non-empty or write in progress
//   overflow                    : sticky dropped-byte flag
//   write_count                 : completed writes, wraps
module loader_write_bridge
   import loader_write_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W     = 22,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [1:0]  SLOT_PHASE = NES_SLOT_PHASE
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_write,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   input  logic [1:0]        nes_ce,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              busy,
   output logic              overflow,
   output logic [ADDR_W-1:0] write_count
);

   localparam int unsigned ENT_W = ADDR_W + DATA_W;

   wr_state_e         state_q, state_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              overflow_q, overflow_d;
   logic [ADDR_W-1:0] write_count_q, write_count_d;

   logic              slot_c;
   logic              pop_c;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ENT_W-1:0]  fifo_head;

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (in_write),
      .wdata   ({in_addr, in_data}),
      .pop     (pop_c),
      .rdata   (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign slot_c = (nes_ce == SLOT_PHASE);

   // Output FSM, completion counter and overflow tracking
   always_comb begin
      state_d       = state_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_data_d    = mem_data_q;
      overflow_d    = overflow_q;
      write_count_d = write_count_q;
      pop_c         = 1'b0;

      if (flush) begin
         state_d    = ST_IDLE;
         mem_we_d   = 1'b0;
         overflow_d = 1'b0;
      end else begin
         if (slot_c) begin
            // Every slot edge seen in WRITE ends one full-period write
            if (state_q == ST_WRITE) write_count_d = write_count_q + ADDR_W'(1);
            if (!fifo_empty) begin
               pop_c      = 1'b1;
               mem_addr_d = fifo_head[ENT_W-1:DATA_W];
               mem_data_d = fifo_head[DATA_W-1:0];
               state_d    = ST_WRITE;
               mem_we_d   = 1'b1;
            end else begin
               state_d    = ST_IDLE;
               mem_we_d   = 1'b0;
            end
         end
         // Dropped only when full and no pop frees the head slot this edge
         if (in_write && fifo_full && !pop_c) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_q    <= '0;
         overflow_q    <= 1'b0;
         write_count_q <= '0;
      end else begin
         state_q       <= state_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_q    <= mem_data_d;
         overflow_q    <= overflow_d;
         write_count_q <= write_count_d;
      end
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data    = mem_data_q;
   assign overflow    = overflow_q;
   assign write_count = write_count_q;
   assign busy        = ~fifo_empty | mem_we_q;

endmodule
